can_crc_engine: RTL
===================

// Module: can_crc_engine
// PURPOSE
//  Parametrised serial CRC engine for the CAN/CAN FD MAC bit path; successor to the fixed CRC-15 LFSR.
//  Generic polynomial, width and seed cover CRC-15 (classic), CRC-17 and CRC-21 (FD).
//  Optionally excludes stuff bits from the CRC, freezes the result at frame end,
//  checks a received frame (zero remainder) or serialises the CRC MSB-first for transmit.
// PARAMETERS
//  W              15       CRC width in bits (15, 17 or 21)
//  POLY           15'h4599 generator polynomial without the x^W term (FD: 17'h1685B, 21'h102899)
//  INIT           0        seed loaded on start/reset (FD CRC-17: 1<<16, CRC-21: 1<<20)
//  INCLUDE_STUFF  0        1: stuff bits enter the CRC (FD); 0: stuff bits skipped (classic)
// PORTS
//  clk           in   1  single clock; all logic on posedge
//  rst           in   1  synchronous, active-high reset
//  start         in   1  pulse: reseed to INIT, enter CALC (legal in any state)
//  din           in   1  serial bit at the sample point
//  din_valid     in   1  bit strobe, one per CAN bit time
//  stuff_bit     in   1  qualifies din_valid: current bit is a stuff bit
//  end_frame     in   1  pulse: last CRC-covered bit reached, freeze result
//  shift_req     in   1  pulse in HOLD: start serialising the CRC
//  crc           out  W  current LFSR contents
//  crc_valid     out  1  high in HOLD (crc frozen, final)
//  crc_ok        out  1  high in HOLD when crc == 0 (RX check passed)
//  tx_bit        out  1  CRC MSB being transmitted (0 outside SHIFT)
//  tx_done       out  1  one-cycle pulse after the W-th transmitted bit
//  busy          out  1  high in CALC or SHIFT
// BEHAVIOUR
//  - Reset: state=IDLE, crc=INIT, crc_valid=crc_ok=tx_bit=tx_done=busy=0. rst beats start.
//  - FSM: IDLE -start-> CALC -end_frame-> HOLD -shift_req-> SHIFT -W strobes-> IDLE.
//    start in any state: crc<=INIT, bit counter cleared, go to CALC next cycle.
//  - CALC update, when din_valid && (INCLUDE_STUFF || !stuff_bit):
//    fb = din ^ crc[W-1]; crc <= {crc[W-2:0],1'b0} ^ (fb ? POLY : 0). One bit per strobe, 1-cycle latency.
//  - din_valid with stuff_bit=1 and INCLUDE_STUFF=0: crc unchanged.
//  - end_frame with din_valid in the same cycle: bit is included, then HOLD.
//  - RX check: the receiver also feeds the W received CRC bits in CALC before end_frame;
//    crc_ok = (crc==0) in HOLD. Combinational from crc, gated by crc_valid.
//  - HOLD: din_valid ignored; crc constant; crc_valid=1 until start, shift_req or rst.
//  - SHIFT: tx_bit = crc[W-1]; on each din_valid (stuff_bit ignored here), crc <= crc<<1
//    and cnt++; when cnt reaches W-1 with a strobe: go to IDLE, tx_done=1 for one cycle,
//    crc reloads INIT.
//  - shift_req outside HOLD, end_frame outside CALC: ignored.
//  - IDLE: all inputs except start ignored.
//  - Counter width $clog2(W+1); no wrap is possible because the FSM leaves SHIFT at W.
// STRUCTURE
//  - Shared package can_pkg: CRC15_POLY/CRC17_POLY/CRC21_POLY, CRC17_INIT/CRC21_INIT constants,
//    state enum (IDLE, CALC, HOLD, SHIFT).
//  - One sub-module crc_lfsr_step: combinational next-state of the LFSR (W, POLY);
//    this module holds the FSM, counter and registers.
// TESTING
//  1 W=15, INIT=0: start, bits 1 -> crc=15'h4599; next bit 0 -> crc=15'h4EAB.
//  2 Random 19-bit data, then end_frame -> crc matches the bench reference model; shift_req ->
//    tx_bit sequence equals crc MSB-first over 15 strobes, tx_done once, back to IDLE.
//  3 RX: data followed by its correct 15 CRC bits -> crc_ok=1; flip one CRC bit -> crc_ok=0.
//  4 INCLUDE_STUFF=0: strobe with stuff_bit=1 -> crc unchanged; INCLUDE_STUFF=1 -> crc updates.
//  5 W=17/POLY=17'h1685B/INIT=1<<16 and W=21 builds: random frames -> match model; RX crc_ok=1.
//  6 rst mid-SHIFT -> IDLE, crc=INIT, outputs 0; start in HOLD -> reseed, CALC, crc_valid drops.

Source files
------------

// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : can_pkg
//  Purpose  : Shared constants and types for the CAN / CAN FD CRC engine.
//             Holds the generator polynomials (without the x^W term), the
//             FD seed values and the engine state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package can_pkg;

  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam logic [16:0] CRC17_POLY = 17'h1685B;
  localparam logic [20:0] CRC21_POLY = 21'h102899;

  localparam logic [16:0] CRC17_INIT = 17'h10000;
  localparam logic [20:0] CRC21_INIT = 21'h100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    HOLD  = 2'd2,
    SHIFT = 2'd3
  } crc_state_e;

endpackage : can_pkg
`default_nettype wire

// File: rtl/crc_lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module   : crc_lfsr_step
//  Purpose  : Combinational single-bit next state of a Galois CRC register.
//             The input bit is folded with the register MSB; when the result
//             is set, the polynomial is XORed into the left-shifted register.
//  Ports    : crc_i  [W-1:0]  current register contents
//             din_i           serial data bit
//             crc_o  [W-1:0]  register contents after absorbing din_i
//  Revision : 1.0 - initial release
// ============================================================================
module crc_lfsr_step #(
  parameter int           W    = 15,
  parameter logic [W-1:0] POLY = 15'h4599
) (
  input  logic [W-1:0] crc_i,
  input  logic         din_i,
  output logic [W-1:0] crc_o
);

  logic w_fb;

  assign w_fb  = din_i ^ crc_i[W-1];
  assign crc_o = {crc_i[W-2:0], 1'b0} ^ (w_fb ? POLY : {W{1'b0}});

endmodule : crc_lfsr_step
`default_nettype wire

// File: rtl/can_crc_engine.sv
`default_nettype none
// ============================================================================
//  Module   : can_crc_engine
//  Purpose  : Serial CRC engine for the CAN / CAN FD bit path. Accumulates
//             the frame CRC, optionally skipping stuff bits, freezes it at
//             frame end for an RX zero-remainder check, and can serialise it
//             MSB-first for transmission.
//  Ports    : clk, rst        clock, synchronous active-high reset
//             start_i         reseed to INIT and enter CALC (any state)
//             din_i           serial bit at the sample point
//             din_valid_i     one strobe per CAN bit time
//             stuff_bit_i     current strobe is a stuff bit
//             end_frame_i     last CRC-covered bit reached
//             shift_req_i     start serialising the frozen CRC
//             crc_o  [W-1:0]  current register contents
//             crc_valid_o     CRC frozen (HOLD)
//             crc_ok_o        frozen CRC is zero
//             tx_bit_o        CRC MSB while serialising, else 0
//             tx_done_o       one-cycle pulse after the last CRC bit
//             busy_o          in CALC or SHIFT
//  Revision : 1.0 - initial release
// ============================================================================
module can_crc_engine
  import can_pkg::*;
#(
  parameter int           W             = 15,
  parameter logic [W-1:0] POLY          = W'(CRC15_POLY),
  parameter logic [W-1:0] INIT          = {W{1'b0}},
  parameter int           INCLUDE_STUFF = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         din_i,
  input  logic         din_valid_i,
  input  logic         stuff_bit_i,
  input  logic         end_frame_i,
  input  logic         shift_req_i,
  output logic [W-1:0] crc_o,
  output logic         crc_valid_o,
  output logic         crc_ok_o,
  output logic         tx_bit_o,
  output logic         tx_done_o,
  output logic         busy_o
);

  // Sized so that W itself is representable; SHIFT exits at W-1 + strobe.
  localparam int CW = $clog2(W + 1);

  crc_state_e    state_q, state_d;
  logic [W-1:0]  crc_q, crc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_done_q, tx_done_d;
  logic [W-1:0]  w_crc_step;
  logic          w_take_bit;

  crc_lfsr_step #(
    .W    (W),
    .POLY (POLY)
  ) u_step (
    .crc_i (crc_q),
    .din_i (din_i),
    .crc_o (w_crc_step)
  );

  assign w_take_bit = din_valid_i && ((INCLUDE_STUFF != 0) || !stuff_bit_i);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      cnt_q     <= '0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    tx_done_d = 1'b0;
    if (start_i) begin
      state_d = CALC;
      crc_d   = INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: ;
        CALC: begin
          // A strobe coinciding with end_frame is still absorbed.
          if (w_take_bit) crc_d = w_crc_step;
          if (end_frame_i) state_d = HOLD;
        end
        HOLD: begin
          if (shift_req_i) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          // Stuff bits are inserted by the bit stuffer downstream, so every
          // strobe consumes one CRC bit here.
          if (din_valid_i) begin
            if (cnt_q == CW'(W - 1)) begin
              state_d   = IDLE;
              crc_d     = INIT;
              cnt_d     = '0;
              tx_done_d = 1'b1;
            end else begin
              crc_d = {crc_q[W-2:0], 1'b0};
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    crc_o       = crc_q;
    crc_valid_o = (state_q == HOLD);
    crc_ok_o    = (state_q == HOLD) && (crc_q == '0);
    tx_bit_o    = (state_q == SHIFT) ? crc_q[W-1] : 1'b0;
    tx_done_o   = tx_done_q;
    busy_o      = (state_q == CALC) || (state_q == SHIFT);
  end

endmodule : can_crc_engine
`default_nettype wire
